// File: rtl/router_pkg.sv
// router_pkg: shared types and constants for the router output scheduler.
//   DW / LENW / HDR_WORDS : default word width, length-field width, header words
//   ROUTE_MSB / ROUTE_LSB : position of the route byte in header word0
//   word_t                : one router data word
//   sched_state_t         : packet-scheduler phases
package router_pkg;

    localparam int DW        = 64;
    localparam int LENW      = 16;
    localparam int HDR_WORDS = 3;
    localparam int ROUTE_MSB = 63;
    localparam int ROUTE_LSB = 56;

    typedef logic [DW-1:0] word_t;

    typedef enum logic [1:0] {IDLE, HDR, LEN, PAY} sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first set request at or after ptr.
//   req : N request bits
//   ptr : highest-priority index this round
//   gnt : one-hot winner, all-zero when req is empty
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] idx;

    // Scan from the farthest candidate back to ptr so the nearest hit wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % N);
            if (req[idx]) gnt = N'(1) << idx;
        end
    end

endmodule

// File: rtl/router_out_sched.sv
// router_out_sched: per-output packet scheduler, round-robin at packet granularity.
//   CLK, RST     : clock, asynchronous active-low reset
//   REQ          : per-input request for this output (head word0 waiting)
//   D, D_VALID   : per-input data words and valids
//   D_BP         : per-input backpressure, 1 = hold word
//   Q, Q_VALID   : muxed output word of the granted input
//   Q_SOF        : marks word0 of a packet on Q
//   Q_BP         : downstream backpressure
//   GNT          : one-hot current grant, zero when idle
module router_out_sched #(
    parameter int N         = 4,
    parameter int DW        = router_pkg::DW,
    parameter int LENW      = router_pkg::LENW,
    parameter int HDR_WORDS = router_pkg::HDR_WORDS
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N-1:0]         REQ,
    input  logic [N-1:0][DW-1:0] D,
    input  logic [N-1:0]         D_VALID,
    output logic [N-1:0]         D_BP,
    output logic [DW-1:0]        Q,
    output logic                 Q_VALID,
    output logic                 Q_SOF,
    input  logic                 Q_BP,
    output logic [N-1:0]         GNT
);

    localparam int PW = $clog2(N);

    router_pkg::sched_state_t state;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gi;
    logic [PW-1:0]   wi;
    logic [1:0]      wcnt;
    logic [LENW-1:0] rem;
    logic [N-1:0]    arb_gnt;
    logic            busy;
    logic            xfer;

    function automatic logic [PW-1:0] oh2idx(input logic [N-1:0] v);
        oh2idx = '0;
        for (int i = 0; i < N; i++)
            if (v[i]) oh2idx = PW'(i);
    endfunction

    rr_arbiter #(.N(N)) u_arb (
        .req (REQ),
        .ptr (ptr),
        .gnt (arb_gnt)
    );

    always_comb begin
        gi      = oh2idx(GNT);
        wi      = oh2idx(arb_gnt);
        busy    = state != router_pkg::IDLE;
        Q       = busy ? D[gi] : '0;
        Q_VALID = busy && D_VALID[gi];
        Q_SOF   = Q_VALID && state == router_pkg::HDR && wcnt == '0;
        // Only the granted input may advance, and only when downstream accepts.
        D_BP    = busy ? (~GNT | (Q_BP ? GNT : '0)) : '1;
        xfer    = Q_VALID && !Q_BP;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= router_pkg::IDLE;
            GNT   <= '0;
            ptr   <= '0;
            wcnt  <= '0;
            rem   <= '0;
        end else begin
            case (state)
                router_pkg::IDLE: if (|REQ) begin
                    GNT   <= arb_gnt;
                    state <= router_pkg::HDR;
                    ptr   <= (wi == PW'(N - 1)) ? '0 : wi + 1'b1;
                    wcnt  <= '0;
                end
                router_pkg::HDR: if (xfer) begin
                    wcnt <= wcnt + 1'b1;
                    if (wcnt == 2'(HDR_WORDS - 2)) state <= router_pkg::LEN;
                end
                router_pkg::LEN: if (xfer) begin
                    rem <= D[gi][LENW-1:0];
                    if (D[gi][LENW-1:0] == '0) begin
                        state <= router_pkg::IDLE;
                        GNT   <= '0;
                    end else begin
                        state <= router_pkg::PAY;
                    end
                end
                router_pkg::PAY: if (xfer) begin
                    rem <= rem - 1'b1;
                    // Exit on the last word so rem never wraps below zero.
                    if (rem == LENW'(1)) begin
                        state <= router_pkg::IDLE;
                        GNT   <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_out_sched.sv
// tb_router_out_sched: randomized packet traffic against a packet-level model with a scoreboard.
module tb_router_out_sched;

    localparam int N    = 4;
    localparam int MAXW = 3 + 15;

    logic                 CLK = 0;
    logic                 RST = 1;
    logic [N-1:0]         REQ = '0;
    logic [N-1:0][63:0]   D = '0;
    logic [N-1:0]         D_VALID = '0;
    logic [N-1:0]         D_BP;
    logic [63:0]          Q;
    logic                 Q_VALID;
    logic                 Q_SOF;
    logic                 Q_BP = 0;
    logic [N-1:0]         GNT;

    always #5 CLK = ~CLK;

    router_out_sched dut (
        .CLK     (CLK),
        .RST     (RST),
        .REQ     (REQ),
        .D       (D),
        .D_VALID (D_VALID),
        .D_BP    (D_BP),
        .Q       (Q),
        .Q_VALID (Q_VALID),
        .Q_SOF   (Q_SOF),
        .Q_BP    (Q_BP),
        .GNT     (GNT)
    );

    typedef struct {
        logic [63:0] w;
        logic        sof;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] pkw[N][MAXW];
    int          plen[N];
    int          widx[N];
    bit          has[N];
    logic [N-1:0] gnted = '0;
    logic [N-1:0] exp_gnt = '0;
    int          ptr_m = 0;
    int          g_m = 0;
    int          left_m = 0;
    bit          busy_m = 0;
    int          bp_cnt = 0;
    int          hold_new = 0;
    bit          run_mon = 0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic newpkt(input int i);
        int l;
        l = ($urandom % 4 == 0) ? 0 : int'($urandom_range(1, 15));
        plen[i] = 3 + l;
        pkw[i][0] = {8'(i + 1), 24'($urandom), 32'($urandom)};
        pkw[i][1] = {$urandom, $urandom};
        pkw[i][2] = {16'($urandom), 32'($urandom), 16'(l)};
        for (int w = 3; w < plen[i]; w++) pkw[i][w] = {$urandom, $urandom};
        widx[i] = 0;
        has[i] = 1;
    endtask

    // Drive one cycle of inputs, then advance the packet-level model to the next edge.
    task automatic drive_cycle(input bit allow_new);
        bit found;
        int c;
        for (int i = 0; i < N; i++)
            if (!has[i] && allow_new && $urandom % 3 == 0) newpkt(i);
        for (int i = 0; i < N; i++) begin
            REQ[i]     = has[i] && !gnted[i];
            D[i]       = has[i] ? pkw[i][widx[i]] : {$urandom, $urandom};
            D_VALID[i] = has[i] ? ($urandom % 5 != 0) : 1'($urandom % 2);
        end
        if (bp_cnt > 0) begin
            Q_BP = 1;
            bp_cnt--;
        end else if ($urandom % 150 == 0) begin
            Q_BP = 1;
            bp_cnt = 16;
        end else begin
            Q_BP = ($urandom % 4 == 0);
        end
        exp_gnt = busy_m ? 4'(1 << g_m) : 4'h0;
        if (busy_m) begin
            if (D_VALID[g_m] && !Q_BP) begin
                widx[g_m]++;
                left_m--;
                if (left_m == 0) begin
                    busy_m = 0;
                    has[g_m] = 0;
                    gnted[g_m] = 0;
                end
            end
        end else if (|REQ) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                c = (ptr_m + k) % N;
                if (!found && REQ[c]) begin
                    found = 1;
                    g_m = c;
                end
            end
            busy_m = 1;
            left_m = plen[g_m];
            gnted[g_m] = 1;
            ptr_m = (g_m + 1) % N;
            for (int w = 0; w < plen[g_m]; w++) sb.push_back('{pkw[g_m][w], w == 0});
        end
    endtask

    always @(negedge CLK) begin
        if (run_mon) begin
            logic [N-1:0] eb;
            exp_t e;
            #2;
            for (int i = 0; i < N; i++) eb[i] = !(exp_gnt[i] && !Q_BP);
            chk("gnt", GNT, exp_gnt);
            chk("d_bp", D_BP, eb);
            chk("q_valid", Q_VALID, |(exp_gnt & D_VALID));
            if (Q_VALID && !Q_BP) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", Q, 64'hX);
                end else begin
                    e = sb.pop_front();
                    chk("q", Q, e.w);
                    chk("q_sof", Q_SOF, e.sof);
                end
            end
        end
    end

    initial begin
        bit did_rst;
        int n;
        did_rst = 0;
        for (int i = 0; i < N; i++) begin
            has[i] = 0;
            widx[i] = 0;
            plen[i] = 0;
        end
        #1 RST = 0;
        #2;
        chk("rst_gnt", GNT, 0);
        chk("rst_q_valid", Q_VALID, 0);
        chk("rst_q_sof", Q_SOF, 0);
        chk("rst_q", Q, 0);
        chk("rst_d_bp", D_BP, 4'hf);
        @(negedge CLK);
        RST = 1;
        run_mon = 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) @(negedge CLK);
            drive_cycle(hold_new == 0);
            if (hold_new > 0) hold_new--;
            if (!did_rst && cyc >= 1500 && busy_m && widx[g_m] >= 7) begin
                did_rst = 1;
                #3 RST = 0;
                #1;
                chk("mid_rst_gnt", GNT, 0);
                chk("mid_rst_q_valid", Q_VALID, 0);
                chk("mid_rst_q_sof", Q_SOF, 0);
                chk("mid_rst_d_bp", D_BP, 4'hf);
                sb.delete();
                busy_m = 0;
                gnted = '0;
                ptr_m = 0;
                exp_gnt = '0;
                REQ = '0;
                for (int i = 0; i < N; i++) has[i] = 0;
                @(negedge CLK);
                @(negedge CLK);
                RST = 1;
                newpkt(1);
                hold_new = 4;
                drive_cycle(0);
            end
        end
        n = 0;
        while (n < 2000 && (busy_m || has[0] || has[1] || has[2] || has[3] || sb.size() != 0)) begin
            @(negedge CLK);
            drive_cycle(0);
            n++;
        end
        @(negedge CLK);
        @(negedge CLK);
        chk("drain_left", 64'(sb.size()), 0);
        chk("did_reset", 64'(did_rst), 1);
        run_mon = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
